// File: rtl/pi1r.sv
// pi1r: single-master to multi-slave PerInt router.
// Decodes the top address bits to pick one slave and forwards the op to it.
// Read responses are returned from the slave that owns them.
// The master stalls while a different slave still owes a response.
// Optional build macro PI1R_ERRCNT_EN adds a saturating counter of
// accesses to the internal error slave (err_cnt_o) with a synchronous
// clear input (err_clr_i).
module pi1r #(
    parameter int unsigned SLAVECOUNT = 4,
    parameter int unsigned ARCHBITSZ  = 16,
    parameter logic [ARCHBITSZ-1:0] ERRDATA = '0,
    localparam int unsigned CLOG2SLAVECOUNT = $clog2(SLAVECOUNT),
    localparam int unsigned SELBITSZ        = ARCHBITSZ / 8,
    localparam int unsigned ADDRBITSZ       = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [1:0]                      m_op_i,
    input  logic [ADDRBITSZ-1:0]            m_addr_i,
    input  logic [ARCHBITSZ-1:0]            m_data_i,
    input  logic [SELBITSZ-1:0]             m_sel_i,
    output logic [ARCHBITSZ-1:0]            m_data_o,
    output logic                            m_rdy_o,
    output logic [2*SLAVECOUNT-1:0]         s_op_o_flat,
    output logic [ADDRBITSZ*SLAVECOUNT-1:0] s_addr_o_flat,
    output logic [ARCHBITSZ*SLAVECOUNT-1:0] s_data_o_flat,
    input  logic [ARCHBITSZ*SLAVECOUNT-1:0] s_data_i_flat,
    output logic [SELBITSZ*SLAVECOUNT-1:0]  s_sel_o_flat,
    input  logic [SLAVECOUNT-1:0]           s_rdy_i_flat
`ifdef PI1R_ERRCNT_EN
    ,
    input  logic                            err_clr_i,
    output logic [15:0]                     err_cnt_o
`endif
);

    localparam logic [1:0] OP_NOOP = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                     state_q;
    logic [CLOG2SLAVECOUNT-1:0] prv_idx_q;
    logic                       prv_err_q;

    logic [CLOG2SLAVECOUNT-1:0] sel_idx;
    logic                       sel_err;
    logic                       sel_rdy;
    logic                       prv_rdy;
    logic                       same_slv;
    logic                       pend;
    logic                       op_valid;
    logic [ARCHBITSZ-1:0]       rsp_data;

    // Slave index taken from the top address bits
    assign sel_idx  = m_addr_i[ADDRBITSZ-1 -: CLOG2SLAVECOUNT];
    assign pend     = (state_q == PEND);
    assign op_valid = (m_op_i != OP_NOOP);

    // Decode new/previous slave: validity, readiness and response data
    always_comb begin
        sel_err  = 1'b1;
        sel_rdy  = 1'b1;
        prv_rdy  = 1'b1;
        rsp_data = ERRDATA;
        for (int k = 0; k < int'(SLAVECOUNT); k++) begin
            if (sel_idx == CLOG2SLAVECOUNT'(k)) begin
                sel_err = 1'b0;
                sel_rdy = s_rdy_i_flat[k];
            end
            if (!prv_err_q && (prv_idx_q == CLOG2SLAVECOUNT'(k))) begin
                prv_rdy  = s_rdy_i_flat[k];
                rsp_data = s_data_i_flat[k*ARCHBITSZ +: ARCHBITSZ];
            end
        end
    end

    // Same slave as the one owing a response (error slave matches error slave)
    assign same_slv = prv_err_q ? sel_err : (!sel_err && (prv_idx_q == sel_idx));

    // Accept only when the target is ready and no other slave blocks the response
    assign m_rdy_o  = rst_i && sel_rdy && (!pend || same_slv || prv_rdy);
    assign m_data_o = rsp_data;

    // Forward the op to the selected slave only; everything else sees NOOP
    always_comb begin
        s_op_o_flat = '0;
        for (int k = 0; k < int'(SLAVECOUNT); k++) begin
            if (m_rdy_o && !sel_err && (sel_idx == CLOG2SLAVECOUNT'(k))) begin
                s_op_o_flat[2*k +: 2] = m_op_i;
            end
        end
    end

    // Address, write data and byte select are broadcast to every slave
    assign s_addr_o_flat = {SLAVECOUNT{m_addr_i}};
    assign s_data_o_flat = {SLAVECOUNT{m_data_i}};
    assign s_sel_o_flat  = {SLAVECOUNT{m_sel_i}};

    // Pending-response FSM and owner tracking; updates only on accepted edges
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            prv_idx_q <= '0;
            prv_err_q <= 1'b0;
        end else if (m_rdy_o) begin
            case (state_q)
                IDLE:    state_q <= m_op_i[1] ? PEND : IDLE;
                PEND:    state_q <= m_op_i[1] ? PEND : IDLE;
                default: state_q <= IDLE;
            endcase
            if (op_valid) begin
                prv_idx_q <= sel_idx;
                prv_err_q <= sel_err;
            end
        end
    end

`ifdef PI1R_ERRCNT_EN
    logic err_acc;

    assign err_acc = m_rdy_o && sel_err && op_valid;

    // Saturating count of accepted ops to the error slave; clear has priority
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_cnt_o <= 16'h0000;
        end else if (err_clr_i) begin
            err_cnt_o <= 16'h0000;
        end else if (err_acc && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`else
    // Error counter not built
`endif

endmodule

// File: doc/pi1r.md
Name: pi1r

Overview:
- Single-master to multi-slave PerInt router; it is the fan-out counterpart of the multi-master queue.
- Decodes the master address and forwards each operation to exactly one slave.
- Returns each read response from the slave that owns it, and stalls the master while a response from a different slave is still outstanding.
- Sits between one CPU-side PerInt master and several peripherals: RAM controller, UART, timer, and similar.

Parameters:
- SLAVECOUNT, 4: number of slave ports; must be >= 2. Decode width is CLOG2SLAVECOUNT = clog2(SLAVECOUNT).
- ARCHBITSZ, 16: data width. ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
- ERRDATA, 0: read data returned for accesses to unmapped slave indexes.

Ports:
- clk_i  in  1  sole clock; all state changes on its rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- m_op_i  in  2  master op: 00 NOOP, 01 WR, 10 RD, 11 RW.
- m_addr_i  in  ADDRBITSZ  master word address.
- m_data_i  in  ARCHBITSZ  master write data.
- m_sel_i  in  ARCHBITSZ/8  byte select.
- m_data_o  out  ARCHBITSZ  response data.
- m_rdy_o  out  1  router ready; accept and response strobe.
- s_op_o_flat  out  2*SLAVECOUNT  per-slave op.
- s_addr_o_flat  out  ADDRBITSZ*SLAVECOUNT  per-slave address (full address replicated).
- s_data_o_flat  out  ARCHBITSZ*SLAVECOUNT  per-slave write data.
- s_data_i_flat  in  ARCHBITSZ*SLAVECOUNT  per-slave response.
- s_sel_o_flat  out  (ARCHBITSZ/8)*SLAVECOUNT  per-slave byte select.
- s_rdy_i_flat  in  SLAVECOUNT  per-slave ready.

Behaviour:
- Protocol (unchanged PerInt):
  - An op is accepted on a clk_i edge where rdy=1 and op != NOOP.
  - The result of an accepted RD or RW is valid on the next cycle with rdy=1 and is taken on that edge.
  - A slave keeps its response valid while its rdy=1 and it receives NOOP.
- Decode: sel = m_addr_i[ADDRBITSZ-1 -: CLOG2SLAVECOUNT].
  - sel >= SLAVECOUNT selects the internal error slave.
  - The error slave is always ready, discards writes, and returns ERRDATA.
- State registers:
  - pend (1 bit): a read response is owed.
  - prvslv (CLOG2SLAVECOUNT bits, plus an error flag): slave owing the response.
- Two states:
  - IDLE: pend = 0.
  - PEND: pend = 1.
- Ready: rdy(x) = s_rdy_i[x], or 1 for the error slave.
- m_rdy_o = rst_i && rdy(sel) && (!pend || prvslv == sel || rdy(prvslv)).
- m_data_o = ERRDATA if prvslv is the error slave, else s_data_i[prvslv]. This holds regardless of pend; the master ignores it when no response is owed.
- Forwarding:
  - s_op_o[k] = m_op_i when k == sel and m_rdy_o = 1; NOOP otherwise.
  - addr, data and sel are broadcast to all slaves; they are don't-care when the op is NOOP.
- Update on each edge with m_rdy_o = 1:
  - pend <= (m_op_i[1] && m_op_i != NOOP).
  - prvslv <= sel if m_op_i != NOOP; otherwise hold.
  - This consumes any prior response on that same edge.
- No update on edges with m_rdy_o = 0.
- Switching slaves while PEND with rdy(prvslv) = 0:
  - m_rdy_o = 0; no op reaches any slave.
  - Stays stalled until the old slave is ready and the new slave is ready in the same cycle.
- WR never sets pend; back-to-back WRs to different slaves incur no stall.
- Reset, asynchronous and active-low:
  - pend = 0, prvslv = 0 (not the error slave).
  - While rst_i = 0: m_rdy_o = 0 and all s_op_o = NOOP.
  - Reset mid-PEND drops the owed response; the master must also be reset.
- Latency: zero-cycle combinational path master to slave; the router adds no pipeline stage.

Optional Feature:
- Macro: PI1R_ERRCNT_EN.
- Enabled:
  - Adds output err_cnt_o (16 bits).
  - Increments by 1 on each accepted op to the error slave.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_i.
  - Adds input err_clr_i (1 bit): synchronous clear; clear wins over a simultaneous increment.
- Disabled: neither port exists and no counter logic is generated.

Test Plan:
- SLAVECOUNT=4, ARCHBITSZ=16. RD to slave 1, then NOOP; slave 1 drives 16'hBEEF with rdy=1 -> m_data_o = 16'hBEEF on the second accepted cycle; only s_op_o[1] = RD during the accept cycle.
- RD to slave 2, then RD to slave 3 while s_rdy_i[2] = 0 for 3 cycles -> m_rdy_o = 0 for 3 cycles and s_op_o[3] = NOOP throughout; s_op_o[3] = RD on the cycle s_rdy_i[2] rises; m_data_o returns slave 2's data that cycle.
- SLAVECOUNT=3, RD to sel=3 -> no slave sees an op; next accept returns ERRDATA; with PI1R_ERRCNT_EN, err_cnt_o = 1.
- Alternate WRs to slaves 0/1/0/1 with all rdy=1 -> m_rdy_o stays 1 for 4 consecutive cycles, with 4 ops forwarded in order.
- Assert rst_i = 0 asynchronously mid-PEND -> m_rdy_o = 0 immediately and all s_op_o = NOOP; after release, a WR to slave 0 is accepted with no stall.
- PI1R_ERRCNT_EN: 3 unmapped accesses, then err_clr_i pulsed together with a 4th unmapped access -> err_cnt_o = 0.
